// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
//
// Walks a downstream 4-to-1 multiplexer through channels 0..3. Each channel's
// select is held for SETTLE_CYCLES cycles so the mux output can settle. The
// returned bit is then captured into data[channel]. After channel 3 the
// complete word is presented with a valid/ready handshake.
//
// Parameters:
//   SETTLE_CYCLES - cycles sel is held per channel before sampling (1..15)
//   AUTO_RESTART  - 1: start a new scan right on the output handshake edge
//
// Optional feature macro:
//   SCAN_PARITY_EN - adds the 'parity' output (even parity of data[3:0]).
//                    It is updated together with data_valid and held in HOLD.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   scan request, only looked at in IDLE
//   sel[1:0]   out  channel select to the multiplexer
//   mux_out    in   bit returned by the multiplexer
//   busy       out  high while scanning or holding a result
//   data[3:0]  out  captured word, data[i] sampled while sel == i
//   data_valid out  data holds a complete scan
//   data_ready in   consumer accepts data (only meaningful in HOLD)
//   parity     out  (SCAN_PARITY_EN only) XOR of data[3:0]
//
// All outputs are registers; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit AUTO_RESTART  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] sel,
    input  logic       mux_out,
    output logic       busy,
    output logic [3:0] data,
    output logic       data_valid,
    input  logic       data_ready
`ifdef SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] channel;
    logic [3:0] count;

    // Single sequential FSM. sel is only rewritten when a SETTLE phase is
    // entered or the block returns to IDLE, so it stays at 3 through HOLD.
    // Bits of data are overwritten one at a time as channels are sampled, so
    // any bit not yet reached keeps its value from the previous scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            channel    <= 2'd0;
            count      <= 4'd0;
            sel        <= 2'd0;
            busy       <= 1'b0;
            data       <= 4'b0000;
            data_valid <= 1'b0;
`ifdef SCAN_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SETTLE;
                        channel <= 2'd0;
                        count   <= 4'd0;
                        sel     <= 2'd0;
                        busy    <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (count == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        count <= count + 4'd1;
                    end
                end

                SAMPLE: begin
                    data[channel] <= mux_out;
                    if (channel == 2'd3) begin
                        state      <= HOLD;
                        data_valid <= 1'b1;
`ifdef SCAN_PARITY_EN
                        // data[3] is being written this edge, so use mux_out
                        parity     <= ^{mux_out, data[2:0]};
`endif
                    end else begin
                        state   <= SETTLE;
                        channel <= channel + 2'd1;
                        sel     <= channel + 2'd1;
                        count   <= 4'd0;
                    end
                end

                HOLD: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        channel    <= 2'd0;
                        count      <= 4'd0;
                        sel        <= 2'd0;
                        if (AUTO_RESTART) begin
                            state <= SETTLE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sequencer
//
// Three instances share clock and reset:
//   u_dut0 - defaults (SETTLE_CYCLES=2, AUTO_RESTART=0)
//   u_dut1 - AUTO_RESTART=1
//   u_dut2 - SETTLE_CYCLES=1
// Each has its own 4-to-1 mux model driven from an 'a' vector. Inputs are
// driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mux_scan_sequencer;

    logic       clk;
    logic       rst_n;

    logic       start0, start1, start2;
    logic       ready0, ready1, ready2;
    logic [3:0] a0, a1, a2;
    logic [1:0] sel0, sel1, sel2;
    logic       busy0, busy1, busy2;
    logic [3:0] data0, data1, data2;
    logic       dv0, dv1, dv2;
    logic       mux0, mux1, mux2;
`ifdef SCAN_PARITY_EN
    logic       par0, par1, par2;
`endif

    int checks;
    int failures;

    // Multiplexer models
    assign mux0 = a0[sel0];
    assign mux1 = a1[sel1];
    assign mux2 = a2[sel2];

    mux_scan_sequencer #(.SETTLE_CYCLES(2), .AUTO_RESTART(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sel(sel0), .mux_out(mux0),
        .busy(busy0), .data(data0), .data_valid(dv0), .data_ready(ready0)
`ifdef SCAN_PARITY_EN
        , .parity(par0)
`endif
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(2), .AUTO_RESTART(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sel(sel1), .mux_out(mux1),
        .busy(busy1), .data(data1), .data_valid(dv1), .data_ready(ready1)
`ifdef SCAN_PARITY_EN
        , .parity(par1)
`endif
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(1), .AUTO_RESTART(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sel(sel2), .mux_out(mux2),
        .busy(busy2), .data(data2), .data_valid(dv2), .data_ready(ready2)
`ifdef SCAN_PARITY_EN
        , .parity(par2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Pulse start on one instance so that it is accepted on the next edge
    task automatic applyStimulus(input int which);
        case (which)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        tick(1);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
        a0 = 4'b0000; a1 = 4'b0000; a2 = 4'b0000;

        // ---- Reset state ----
        tick(2);
        checkOutput("rst_sel",  {6'd0, sel0}, 8'd0);
        checkOutput("rst_busy", {7'd0, busy0}, 8'd0);
        checkOutput("rst_data", {4'd0, data0}, 8'd0);
        checkOutput("rst_dv",   {7'd0, dv0}, 8'd0);
        rst_n = 1'b1;
        tick(2);

        // ---- Basic scan, ready held high ----
        $display("[TB] basic scan a=1010");
        a0 = 4'b1010;
        ready0 = 1'b1;
        applyStimulus(0);
        checkOutput("t1_busy_start", {7'd0, busy0}, 8'd1);
        checkOutput("t1_sel_start",  {6'd0, sel0}, 8'd0);
        tick(11);
        checkOutput("t1_dv_early", {7'd0, dv0}, 8'd0);
        tick(1);
        checkOutput("t1_dv",   {7'd0, dv0}, 8'd1);
        checkOutput("t1_data", {4'd0, data0}, 8'b1010);
        checkOutput("t1_sel_hold", {6'd0, sel0}, 8'd3);
`ifdef SCAN_PARITY_EN
        checkOutput("t1_parity", {7'd0, par0}, 8'd0);
`endif
        tick(1);
        checkOutput("t1_dv_after",   {7'd0, dv0}, 8'd0);
        checkOutput("t1_busy_after", {7'd0, busy0}, 8'd0);
        checkOutput("t1_sel_after",  {6'd0, sel0}, 8'd0);
        ready0 = 1'b0;
        tick(2);

        // ---- Held result while ready low ----
        $display("[TB] hold a=0111");
        a0 = 4'b0111;
        applyStimulus(0);
        tick(12);
        checkOutput("t2_dv", {7'd0, dv0}, 8'd1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checkOutput("t2_hold_dv",   {7'd0, dv0}, 8'd1);
            checkOutput("t2_hold_data", {4'd0, data0}, 8'b0111);
        end
`ifdef SCAN_PARITY_EN
        checkOutput("t2_parity", {7'd0, par0}, 8'd1);
`endif
        ready0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
        checkOutput("t2_dv_after",   {7'd0, dv0}, 8'd0);
        checkOutput("t2_busy_after", {7'd0, busy0}, 8'd0);
        checkOutput("t2_data_keep",  {4'd0, data0}, 8'b0111);
        tick(2);

        // ---- Start while busy is ignored; partial overwrite visible ----
        $display("[TB] start while busy a=1100");
        a0 = 4'b1100;
        applyStimulus(0);
        for (int t = 1; t <= 12; t++) begin
            tick(1);
            if (t == 5) start0 = 1'b1;
            if (t == 6) start0 = 1'b0;
            if (t == 3)  checkOutput("t3_data_ch0", {4'd0, data0}, 8'b0110);
            if (t == 6)  checkOutput("t3_data_ch1", {4'd0, data0}, 8'b0100);
            if (t == 11) checkOutput("t3_dv_early", {7'd0, dv0}, 8'd0);
        end
        checkOutput("t3_dv",   {7'd0, dv0}, 8'd1);
        checkOutput("t3_data", {4'd0, data0}, 8'b1100);
        // start coincident with the handshake edge must not launch a scan
        ready0 = 1'b1;
        start0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
        start0 = 1'b0;
        checkOutput("t3_hs_busy", {7'd0, busy0}, 8'd0);
        tick(15);
        checkOutput("t3_no_rescan_busy", {7'd0, busy0}, 8'd0);
        checkOutput("t3_no_rescan_dv",   {7'd0, dv0}, 8'd0);

        // ---- Reset mid-scan ----
        $display("[TB] reset mid-scan");
        a0 = 4'b0101;
        applyStimulus(0);
        tick(7);
        rst_n = 1'b0;
        #1;
        checkOutput("t4_sel",  {6'd0, sel0}, 8'd0);
        checkOutput("t4_busy", {7'd0, busy0}, 8'd0);
        checkOutput("t4_data", {4'd0, data0}, 8'd0);
        checkOutput("t4_dv",   {7'd0, dv0}, 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        checkOutput("t4_idle_dv",   {7'd0, dv0}, 8'd0);
        checkOutput("t4_idle_busy", {7'd0, busy0}, 8'd0);
        checkOutput("t4_idle_data", {4'd0, data0}, 8'd0);

        // ---- Auto restart ----
        $display("[TB] auto restart");
        a1 = 4'b0001;
        applyStimulus(1);
        tick(12);
        checkOutput("t5_dv1",   {7'd0, dv1}, 8'd1);
        checkOutput("t5_data1", {4'd0, data1}, 8'b0001);
        ready1 = 1'b1;
        tick(1);
        ready1 = 1'b0;
        a1 = 4'b1000;
        checkOutput("t5_hs_dv",   {7'd0, dv1}, 8'd0);
        checkOutput("t5_hs_busy", {7'd0, busy1}, 8'd1);
        checkOutput("t5_hs_sel",  {6'd0, sel1}, 8'd0);
        tick(11);
        checkOutput("t5_dv_early", {7'd0, dv1}, 8'd0);
        tick(1);
        checkOutput("t5_dv2",   {7'd0, dv1}, 8'd1);
        checkOutput("t5_data2", {4'd0, data1}, 8'b1000);
`ifdef SCAN_PARITY_EN
        checkOutput("t5_parity", {7'd0, par1}, 8'd1);
`endif

        // ---- SETTLE_CYCLES = 1 ----
        $display("[TB] settle=1 a=0110");
        a2 = 4'b0110;
        applyStimulus(2);
        checkOutput("t6_sel0", {6'd0, sel2}, 8'd0);
        for (int t = 1; t <= 7; t++) begin
            tick(1);
            checkOutput("t6_sel_seq", {6'd0, sel2}, 8'(t / 2));
        end
        checkOutput("t6_dv_early", {7'd0, dv2}, 8'd0);
        tick(1);
        checkOutput("t6_dv",   {7'd0, dv2}, 8'd1);
        checkOutput("t6_data", {4'd0, data2}, 8'b0110);
`ifdef SCAN_PARITY_EN
        checkOutput("t6_parity", {7'd0, par2}, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, cycles sel is held per channel before sampling (legal 1..15).
REQ-002 SHALL have parameter AUTO_RESTART, default 0; 1 = begin a new scan immediately after each output handshake.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  scan request, sampled only in IDLE.
REQ-006 SHALL have port sel  output  2  channel select driven to the downstream 4-to-1 multiplexer.
REQ-007 SHALL have port mux_out  input  1  selected bit returned by the multiplexer.
REQ-008 SHALL have port busy  output  1  high in SETTLE, SAMPLE and HOLD.
REQ-009 SHALL have port data  output  4  captured word; data[i] = mux_out while sel == i.
REQ-010 SHALL have port data_valid  output  1  data holds a complete scan.
REQ-011 SHALL have port data_ready  input  1  consumer accepts data.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE, HOLD; registered outputs only, no combinational path from any input to any output.
REQ-013 IDLE: sel = 0, busy = 0; start = 1 -> SETTLE with channel 0, settle counter 0.
REQ-014 SETTLE: sel = current channel; counter increments each cycle; when counter == SETTLE_CYCLES-1 -> SAMPLE.
REQ-015 SAMPLE: data[channel] <= mux_out; channel < 3 -> channel+1, counter 0, SETTLE; channel == 3 -> HOLD, data_valid <= 1.
REQ-016 Latency: data_valid SHALL rise exactly 4*(SETTLE_CYCLES+1) cycles after the edge on which start is accepted (12 at default).
REQ-017 HOLD: data and data_valid SHALL remain stable until data_valid && data_ready on a rising edge.
REQ-018 On the handshake edge: data_valid <= 0; AUTO_RESTART = 0 -> IDLE; AUTO_RESTART = 1 -> SETTLE at channel 0 with no idle cycle.
REQ-019 start while busy SHALL be ignored, not queued; start on the handshake edge is ignored (accepted only from IDLE on a later cycle).
REQ-020 data_ready outside HOLD SHALL have no effect.
REQ-021 data bits not yet overwritten in a scan SHALL retain the previous scan's values until sampled.
REQ-022 Channel index SHALL never wrap past 3 inside a scan; sel only changes on SETTLE entry or return to IDLE.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, sel = 0, busy = 0, data = 4'b0000, data_valid = 0, counter = 0, channel = 0, parity = 0 (when present).
REQ-024 Reset asserted mid-scan or in HOLD SHALL abort without completing the handshake; after release, no activity until a new start.

Configuration
REQ-025 Macro SCAN_PARITY_EN defined: SHALL add port parity  output  1, updated with data_valid to even parity (XOR of data[3:0]) and held through HOLD.
REQ-026 Macro SCAN_PARITY_EN undefined: the parity port and its logic SHALL not exist; all other behaviour is identical.

Verification
REQ-027 Bench-modelled mux with a = 4'b1010, start pulse, data_ready = 1 -> data_valid high 12 cycles after start, data = 4'b1010, parity = 0 when enabled.
REQ-028 a = 4'b0111, data_ready held low 20 cycles -> data = 4'b0111 and data_valid stable throughout; one-cycle ready -> data_valid low next cycle, FSM in IDLE.
REQ-029 start pulsed again at cycle 5 of a scan with a = 4'b1100 -> ignored; exactly one completed scan, data = 4'b1100.
REQ-030 rst_n low at cycle 7 of a scan -> all outputs at reset values immediately; no data_valid without a new start.
REQ-031 AUTO_RESTART = 1, a changed from 4'b0001 to 4'b1000 after the first handshake -> second data_valid 12 cycles after the first handshake with data = 4'b1000.
REQ-032 SETTLE_CYCLES = 1, a = 4'b0110 -> sel sequence 0,0,1,1,2,2,3,3, data_valid 8 cycles after start, data = 4'b0110.
